// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit limits for the MM:SS stopwatch
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  localparam int unsigned UNIT_MAX = 9;
  localparam int unsigned TENS_MAX = 5;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/stopwatch_mmss_if.sv
// rtl/stopwatch_mmss_if.sv - command inputs and display outputs of the stopwatch
interface stopwatch_mmss_if;
  import stopwatch_pkg::*;

  logic start_stop;
  logic clear;
  logic lap;
  bcd_t sec_u;
  bcd_t sec_t;
  bcd_t min_u;
  bcd_t min_t;
  logic running;
  logic tick;
  logic wrap;

  modport master (
    output start_stop, clear, lap,
    input  sec_u, sec_t, min_u, min_t, running, tick, wrap
  );

  modport slave (
    input  start_stop, clear, lap,
    output sec_u, sec_t, min_u, min_t, running, tick, wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD counter digit that rolls over at MAX and reports a carry
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = UNIT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  // Carry is purely a function of this digit being at its limit when asked to step.
  assign carry = inc && (q == bcd_t'(MAX));

  // Clear has priority over increment so a simultaneous tick is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= carry ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_mmss.sv
// rtl/stopwatch_mmss.sv - MM:SS BCD stopwatch with start/pause/clear FSM; LAP_HOLD_EN adds lap hold
module stopwatch_mmss
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned PRESC_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_mmss_if.slave  sw
);

  logic              ss_d, clr_d;
  logic              ss_edge, clr_edge;
  sw_state_t         state, state_nx;
  logic              running_q;
  logic [PRESC_W-1:0] presc;
  logic              presc_last, tick_int, wrap_int;
  logic              tick_q, wrap_q;
  bcd_t              su_q, st_q, mu_q, mt_q;
  logic              su_c, st_c, mu_c;

  assign ss_edge  = sw.start_stop & ~ss_d;
  assign clr_edge = sw.clear & ~clr_d;

  // Delay each command level by one cycle so a held level yields one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_d  <= 1'b0;
      clr_d <= 1'b0;
    end else begin
      ss_d  <= sw.start_stop;
      clr_d <= sw.clear;
    end
  end

  // State register; running tracks the state it enters on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      running_q <= 1'b0;
    end else begin
      state     <= state_nx;
      running_q <= (state_nx == RUN);
    end
  end

  // Next state: clear beats start_stop, start_stop toggles RUN and PAUSE.
  always_comb begin
    state_nx = state;
    if (clr_edge) begin
      state_nx = IDLE;
    end else if (ss_edge) begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign presc_last = (presc == PRESC_W'(CLK_DIV - 1));
  assign tick_int   = (state == RUN) && presc_last;

  // Prescaler only advances in RUN, so PAUSE keeps the partial second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr_edge) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= presc_last ? '0 : presc + PRESC_W'(1);
    end
  end

  bcd_digit #(.MAX(UNIT_MAX)) u_sec_u (.clk(clk), .rst(rst), .clr(clr_edge), .inc(tick_int), .q(su_q), .carry(su_c));
  bcd_digit #(.MAX(TENS_MAX)) u_sec_t (.clk(clk), .rst(rst), .clr(clr_edge), .inc(su_c),     .q(st_q), .carry(st_c));
  bcd_digit #(.MAX(UNIT_MAX)) u_min_u (.clk(clk), .rst(rst), .clr(clr_edge), .inc(st_c),     .q(mu_q), .carry(mu_c));
  bcd_digit #(.MAX(TENS_MAX)) u_min_t (.clk(clk), .rst(rst), .clr(clr_edge), .inc(mu_c),     .q(mt_q), .carry(wrap_int));

  // Register tick and wrap so they line up with the digits they produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= tick_int;
      wrap_q <= wrap_int;
    end
  end

  assign sw.running = running_q;
  assign sw.tick    = tick_q;
  assign sw.wrap    = wrap_q;

`ifdef LAP_HOLD_EN
  logic lap_d;
  logic lap_edge;
  logic hold;
  bcd_t snap_su, snap_st, snap_mu, snap_mt;

  assign lap_edge = sw.lap & ~lap_d;

  // Lap edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_d <= 1'b0;
    else     lap_d <= sw.lap;
  end

  // Lap toggles hold only while running; entering hold freezes the live digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= 1'b0;
      snap_su <= '0;
      snap_st <= '0;
      snap_mu <= '0;
      snap_mt <= '0;
    end else if (clr_edge) begin
      hold <= 1'b0;
    end else if (lap_edge && (state == RUN)) begin
      hold <= ~hold;
      if (!hold) begin
        snap_su <= su_q;
        snap_st <= st_q;
        snap_mu <= mu_q;
        snap_mt <= mt_q;
      end
    end
  end

  assign sw.sec_u = hold ? snap_su : su_q;
  assign sw.sec_t = hold ? snap_st : st_q;
  assign sw.min_u = hold ? snap_mu : mu_q;
  assign sw.min_t = hold ? snap_mt : mt_q;
`else
  logic unused_lap;
  assign unused_lap = sw.lap;

  assign sw.sec_u = su_q;
  assign sw.sec_t = st_q;
  assign sw.min_u = mu_q;
  assign sw.min_t = mt_q;
`endif

endmodule

// File: tb/tb_stopwatch_mmss.sv
// tb/tb_stopwatch_mmss.sv - scoreboard bench for stopwatch_mmss against a seconds-count model
module tb_stopwatch_mmss;
  import stopwatch_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  typedef struct {
    logic [15:0] disp;
    logic        wrap;
  } tick_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_mmss_if sw();

  stopwatch_mmss #(.CLK_DIV(CLK_DIV), .PRESC_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  int vectors = 0;
  int miscompares = 0;

  int total, phase, mode, snap;
  bit hold, pss, pcl, plp;
  logic [15:0] exp_disp;
  logic exp_run, exp_tick, exp_wrap;
  bit mon_en = 0;
  tick_exp_t q_exp[$];

  function automatic logic [15:0] bcd4(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    total = 0; phase = 0; mode = M_IDLE; snap = 0; hold = 0;
    pss = 0; pcl = 0; plp = 0;
    exp_disp = '0; exp_run = 0; exp_tick = 0; exp_wrap = 0;
    q_exp.delete();
  endtask

  // One clock cycle: drive levels, predict the next edge from seconds arithmetic, commit after it.
  task automatic cycle(input bit ss, input bit cl, input bit lp);
    bit e_ss, e_cl, e_lp, t, w, n_hold;
    int n_total, n_phase, n_mode, n_snap;
    logic [15:0] disp;
    sw.start_stop = ss;
    sw.clear = cl;
    sw.lap = lp;
    e_ss = ss && !pss;
    e_cl = cl && !pcl;
    e_lp = lp && !plp;
    t = (mode == M_RUN) && (phase == CLK_DIV - 1);
    w = t && (total == 3599);
    n_total = total; n_phase = phase; n_mode = mode; n_snap = snap; n_hold = hold;
    if (e_cl) begin
      n_total = 0; n_phase = 0; n_mode = M_IDLE; n_hold = 0;
    end else begin
      if (t) n_total = (total + 1) % 3600;
      if (mode == M_RUN) n_phase = (phase + 1) % CLK_DIV;
      if (e_ss) n_mode = (mode == M_RUN) ? M_PAUSE : M_RUN;
`ifdef LAP_HOLD_EN
      if (e_lp && mode == M_RUN) begin
        n_hold = !hold;
        if (!hold) n_snap = total;
      end
`endif
    end
    disp = n_hold ? bcd4(n_snap) : bcd4(n_total);
    if (t) q_exp.push_back('{disp: disp, wrap: w});
    @(posedge clk);
    total = n_total; phase = n_phase; mode = n_mode; snap = n_snap; hold = n_hold;
    pss = ss; pcl = cl; plp = e_lp ? 1'b1 : lp;
    exp_disp = disp; exp_run = (n_mode == M_RUN); exp_tick = t; exp_wrap = w;
    #1;
  endtask

  // Monitor: per-cycle status checks, and a scoreboard pop whenever the DUT shows a tick.
  initial begin
    tick_exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("running", 16'(sw.running), 16'(exp_run));
        chk("display", {sw.min_t, sw.min_u, sw.sec_t, sw.sec_u}, exp_disp);
        chk("tick", 16'(sw.tick), 16'(exp_tick));
        if (sw.tick) begin
          if (q_exp.size() == 0) begin
            chk("unexpected_tick", 16'(sw.tick), 16'd0);
          end else begin
            e = q_exp.pop_front();
            chk("tick_display", {sw.min_t, sw.min_u, sw.sec_t, sw.sec_u}, e.disp);
            chk("tick_wrap", 16'(sw.wrap), 16'(e.wrap));
          end
        end else begin
          chk("wrap_idle", 16'(sw.wrap), 16'(exp_wrap));
        end
      end
    end
  end

  initial begin
    bit lss, lcl, llp;
    rst = 1'b1;
    sw.start_stop = 0; sw.clear = 0; sw.lap = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_display", {sw.min_t, sw.min_u, sw.sec_t, sw.sec_u}, 16'h0000);
    chk("reset_running", 16'(sw.running), 16'd0);
    chk("reset_tick", 16'(sw.tick), 16'd0);
    chk("reset_wrap", 16'(sw.wrap), 16'd0);
    rst = 1'b0;
    mon_en = 1;

    // Start with a held level, run past a minute boundary.
    repeat (8) cycle(1, 0, 0);
    repeat (260) cycle(0, 0, 0);

    // Pause mid-second, hold, resume.
    cycle(0, 0, 0); cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (30) cycle(0, 0, 0);

    // Lap hold around a few ticks.
    cycle(0, 0, 1);
    repeat (22) cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (6) cycle(0, 0, 0);

    // Clear and start_stop rising together while running.
    cycle(1, 1, 0);
    repeat (6) cycle(0, 0, 0);

    // Full hour run through 59:59 -> 00:00.
    cycle(1, 0, 0);
    repeat (3600 * CLK_DIV + 40) cycle(0, 0, 0);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    sw.start_stop = 0; sw.clear = 0; sw.lap = 0;
    model_reset();
    #1;
    chk("async_reset_display", {sw.min_t, sw.min_u, sw.sec_t, sw.sec_u}, 16'h0000);
    chk("async_reset_running", 16'(sw.running), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random command levels.
    lss = 0; lcl = 0; llp = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) lss = !lss;
      if ($urandom_range(63) == 0) lcl = !lcl;
      if ($urandom_range(15) == 0) llp = !llp;
      cycle(lss, lcl, llp);
    end
    repeat (4) cycle(0, 0, 0);

    chk("pending_ticks", 16'(q_exp.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
